// File: rtl/spi_pkg.sv
// Shared SPI definitions for the master and slave ends of the board link.
package spi_pkg;

  localparam int unsigned SPI_DATA_W      = 8;
  localparam int unsigned SPI_SYNC_STAGES = 2;

  // Union of master and slave states; the slave uses IDLE, RECV and DONE.
  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TRANSFER,
    DONE,
    RECV
  } spi_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin with rise/fall detection.
module spi_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q      = sync_q[STAGES-1];
  assign rise_c = q & ~prev_q;
  assign fall_c = ~q & prev_q;

endmodule

// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave: oversampled receive into bytes, valid/ready hand-off, miso response.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W      = SPI_DATA_W,
  parameter int unsigned SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              overrun,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  spi_state_t        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] tx_shift;

  logic sclk_s, sclk_rise_c, sclk_fall_c;
  logic cs_s, cs_rise_c, cs_fall_c;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk),
    .q(sclk_s), .rise_c(sclk_rise_c), .fall_c(sclk_fall_c)
  );

  // cs_n idles high, so its chain resets high to avoid a false frame start.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n),
    .q(cs_s), .rise_c(cs_rise_c), .fall_c(cs_fall_c)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi),
    .q(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused)
  );

  // Frame FSM, bit counter, shift registers and rx hand-off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;

      if (rx_valid && rx_ready && (state != DONE)) begin
        rx_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (cs_fall_c) begin
            state    <= RECV;
            tx_shift <= tx_data;
            bit_cnt  <= '0;
          end
        end

        RECV: begin
          if (cs_rise_c) begin
            // cs_n wins over a coincident sclk edge; partial byte is dropped.
            state     <= IDLE;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
            rx_shift  <= '0;
          end else begin
            if (sclk_rise_c) begin
              rx_shift <= {rx_shift[DATA_W-2:0], mosi_s};
              bit_cnt  <= bit_cnt + CNT_W'(1);
              if (bit_cnt == LAST_BIT) begin
                state <= DONE;
              end
            end
            // A fall before the first rise is the tail of the previous frame;
            // shifting on it would lose the freshly loaded response MSB.
            if (sclk_fall_c && (bit_cnt != '0)) begin
              tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
            end
          end
        end

        DONE: begin
          if (!rx_valid || rx_ready) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          bit_cnt  <= '0;
          tx_shift <= tx_data;
          state    <= cs_s ? IDLE : RECV;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign miso_oe = ~cs_s;
  assign miso    = miso_oe & tx_shift[DATA_W-1];
  assign busy    = (state != IDLE);

endmodule
